// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pkg
//  Description : Shared types and helpers for the streaming radix-2 FFT:
//                FSM states, ceil-log2, bit reversal, Q1.15 twiddle ROM.
//  Revision    : 1.0  initial release
// ============================================================================
package fft_pkg;

   typedef enum logic [1:0] {
      ST_LOAD    = 2'd0,
      ST_COMPUTE = 2'd1,
      ST_UNLOAD  = 2'd2
   } state_e;

   localparam int TW_N_MAX = 64;   // twiddle table resolution (points per circle)
   localparam int TW_ROM_W = 16;   // Q1.15 storage width

   typedef struct packed {
      logic signed [TW_ROM_W-1:0] c;   // cos
      logic signed [TW_ROM_W-1:0] s;   // sin
   } tw_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   // Reverse the lower 'bits' bits of v
   function automatic logic [5:0] bitrev(input logic [5:0] v, input int bits);
      logic [5:0] r;
      r = '0;
      for (int i = 0; i < 6; i++) begin
         if (i < bits) r = r | (6'(v[i]) << (bits - 1 - i));
      end
      return r;
   endfunction

   // cos(2*pi*j/64) in Q1.15 for the first quadrant, j = 0..16 (1.0 clipped)
   function automatic logic signed [15:0] cos_q(input logic [4:0] j);
      case (j)
         5'd0:    return 16'sd32767;
         5'd1:    return 16'sd32610;
         5'd2:    return 16'sd32138;
         5'd3:    return 16'sd31357;
         5'd4:    return 16'sd30274;
         5'd5:    return 16'sd28899;
         5'd6:    return 16'sd27246;
         5'd7:    return 16'sd25330;
         5'd8:    return 16'sd23170;
         5'd9:    return 16'sd20788;
         5'd10:   return 16'sd18205;
         5'd11:   return 16'sd15447;
         5'd12:   return 16'sd12540;
         5'd13:   return 16'sd9512;
         5'd14:   return 16'sd6393;
         5'd15:   return 16'sd3212;
         default: return 16'sd0;
      endcase
   endfunction

   // cos/sin of 2*pi*idx/TW_N_MAX over the half circle idx = 0..31
   function automatic tw_t tw(input logic [4:0] idx);
      tw_t r;
      if (idx <= 5'd16) begin
         r.c = cos_q(idx);
         r.s = cos_q(5'd16 - idx);
      end else begin
         r.c = -cos_q(5'(6'd32 - {1'b0, idx}));
         r.s = cos_q(idx - 5'd16);
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fft_bfly_r2.sv
`default_nettype none
// ============================================================================
//  Module      : fft_bfly_r2
//  Description : Combinational radix-2 DIT butterfly: A' = A + W*B,
//                B' = A - W*B, rounded complex multiply, optional >>>1.
//  Revision    : 1.0  initial release
// ============================================================================
module fft_bfly_r2 import fft_pkg::*; #(
   parameter int OW    = 27,
   parameter int TW_W  = 16,
   parameter int SCALE = 0
) (
   input  logic signed [OW-1:0]   a_re_i,
   input  logic signed [OW-1:0]   a_im_i,
   input  logic signed [OW-1:0]   b_re_i,
   input  logic signed [OW-1:0]   b_im_i,
   input  logic signed [TW_W-1:0] w_re_i,
   input  logic signed [TW_W-1:0] w_im_i,
   input  logic                   bypass_i,   // W = 1, skip the multiplier
   output logic signed [OW-1:0]   a_re_o,
   output logic signed [OW-1:0]   a_im_o,
   output logic signed [OW-1:0]   b_re_o,
   output logic signed [OW-1:0]   b_im_o
);

   localparam int PW = OW + TW_W + 1;
   localparam logic signed [PW-1:0] RND = PW'(1) <<< (TW_W - 2);

   logic signed [PW-1:0] prod_re, prod_im;
   logic signed [OW-1:0] wb_re, wb_im;
   logic signed [OW:0]   sum_re, sum_im, dif_re, dif_im;

   // complex multiply with round-half-up, then add/sub and optional halving
   always_comb begin
      prod_re = PW'(b_re_i) * PW'(w_re_i) - PW'(b_im_i) * PW'(w_im_i) + RND;
      prod_im = PW'(b_re_i) * PW'(w_im_i) + PW'(b_im_i) * PW'(w_re_i) + RND;
      if (bypass_i) begin
         wb_re = b_re_i;
         wb_im = b_im_i;
      end else begin
         wb_re = OW'(prod_re >>> (TW_W - 1));
         wb_im = OW'(prod_im >>> (TW_W - 1));
      end
      sum_re = (OW+1)'(a_re_i) + (OW+1)'(wb_re);
      sum_im = (OW+1)'(a_im_i) + (OW+1)'(wb_im);
      dif_re = (OW+1)'(a_re_i) - (OW+1)'(wb_re);
      dif_im = (OW+1)'(a_im_i) - (OW+1)'(wb_im);
      a_re_o = OW'(sum_re >>> SCALE);
      a_im_o = OW'(sum_im >>> SCALE);
      b_re_o = OW'(dif_re >>> SCALE);
      b_im_o = OW'(dif_im >>> SCALE);
   end

endmodule
`default_nettype wire

// File: rtl/fft_r2_stream.sv
`default_nettype none
// ============================================================================
//  Module      : fft_r2_stream
//  Description : Sample-serial radix-2 DIT FFT/IFFT. Loads a frame in
//                bit-reversed order, runs (N/2)*log2(N) in-place butterflies
//                on one shared butterfly, streams bins out in natural order.
//  Revision    : 1.0  initial release
// ============================================================================
module fft_r2_stream import fft_pkg::*; #(
   parameter  int N     = 8,
   parameter  int DW    = 24,
   parameter  int TW_W  = 16,
   parameter  int SCALE = 0,
   localparam int LOG2N = clog2(N),
   localparam int OW    = (SCALE != 0) ? DW : DW + LOG2N
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic signed [DW-1:0]  in_real,
   input  logic signed [DW-1:0]  in_imag,
   input  logic                  in_inv,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic signed [OW-1:0]  out_real,
   output logic signed [OW-1:0]  out_imag,
   output logic [LOG2N-1:0]      out_index,
   output logic                  out_last,
   output logic                  busy
);

   localparam int         BW         = LOG2N - 1;          // butterflies per stage = 2^BW
   localparam logic [2:0] LAST_STAGE = 3'(LOG2N - 1);

   state_e               state_q, state_d;
   logic [LOG2N-1:0]     idx_q;       // load sample / unload bin counter
   logic [BW-1:0]        bfly_q;      // butterfly within the stage
   logic [2:0]           stage_q;     // stage s-1, span h = 2^stage_q
   logic                 inv_q;
   logic signed [OW-1:0] re_q [N];
   logic signed [OW-1:0] im_q [N];

   logic                 in_hs, out_hs, last_bfly;
   logic [LOG2N-1:0]     mask, k_w, a_idx, b_idx;
   logic [4:0]           tw_idx;
   tw_t                  tw_w;
   logic signed [TW_W-1:0] w_re, w_im;
   logic signed [OW-1:0] a_re_n, a_im_n, b_re_n, b_im_n;

   assign in_ready  = (state_q == ST_LOAD);
   assign out_valid = (state_q == ST_UNLOAD);
   assign busy      = (state_q != ST_LOAD);
   assign in_hs     = in_valid & in_ready;
   assign out_hs    = out_valid & out_ready;
   assign last_bfly = (stage_q == LAST_STAGE) && (&bfly_q);

   // pair addresses (a, a+h) and twiddle index k*(64/2h) for the current butterfly
   always_comb begin
      mask   = LOG2N'((32'd1 << stage_q) - 32'd1);
      k_w    = {1'b0, bfly_q} & mask;
      a_idx  = (({1'b0, bfly_q} & ~mask) << 1) | k_w;
      b_idx  = a_idx | LOG2N'(32'd1 << stage_q);
      tw_idx = 5'(k_w) << (3'd5 - stage_q);
      tw_w   = tw(tw_idx);
      w_re   = TW_W'(tw_w.c >>> (TW_ROM_W - TW_W));
      // forward uses cos - j*sin, inverse the conjugate
      w_im   = inv_q ? TW_W'(tw_w.s >>> (TW_ROM_W - TW_W))
                     : TW_W'((-tw_w.s) >>> (TW_ROM_W - TW_W));
   end

   fft_bfly_r2 #(
      .OW    (OW),
      .TW_W  (TW_W),
      .SCALE (SCALE)
   ) u_bfly (
      .a_re_i   (re_q[a_idx]),
      .a_im_i   (im_q[a_idx]),
      .b_re_i   (re_q[b_idx]),
      .b_im_i   (im_q[b_idx]),
      .w_re_i   (w_re),
      .w_im_i   (w_im),
      .bypass_i (k_w == '0),
      .a_re_o   (a_re_n),
      .a_im_o   (a_im_n),
      .b_re_o   (b_re_n),
      .b_im_o   (b_im_n)
   );

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_LOAD;
      else     state_q <= state_d;
   end

   // next-state: full frame -> compute -> unload -> back to load
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_LOAD:    if (in_hs && (&idx_q))  state_d = ST_COMPUTE;
         ST_COMPUTE: if (last_bfly)          state_d = ST_UNLOAD;
         ST_UNLOAD:  if (out_hs && (&idx_q)) state_d = ST_LOAD;
         default:                            state_d = ST_LOAD;
      endcase
   end

   // sample/bin, butterfly and stage counters; direction latched on sample 0
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q   <= '0;
         bfly_q  <= '0;
         stage_q <= '0;
         inv_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_LOAD: begin
               if (in_hs) begin
                  idx_q <= idx_q + 1'b1;
                  if (idx_q == '0) inv_q <= in_inv;
               end
            end
            ST_COMPUTE: begin
               bfly_q <= bfly_q + 1'b1;
               if (&bfly_q) stage_q <= last_bfly ? 3'd0 : stage_q + 3'd1;
            end
            ST_UNLOAD: begin
               if (out_hs) idx_q <= idx_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // frame buffer: bit-reversed load, in-place butterfly write-back
   always_ff @(posedge clk) begin
      if (in_hs) begin
         re_q[LOG2N'(bitrev(6'(idx_q), LOG2N))] <= OW'(in_real);
         im_q[LOG2N'(bitrev(6'(idx_q), LOG2N))] <= OW'(in_imag);
      end else if (state_q == ST_COMPUTE) begin
         re_q[a_idx] <= a_re_n;
         im_q[a_idx] <= a_im_n;
         re_q[b_idx] <= b_re_n;
         im_q[b_idx] <= b_im_n;
      end
   end

   assign out_real  = out_valid ? re_q[idx_q] : '0;
   assign out_imag  = out_valid ? im_q[idx_q] : '0;
   assign out_index = out_valid ? idx_q : '0;
   assign out_last  = out_valid & (&idx_q);

endmodule
`default_nettype wire
